fifo_stream_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It drives the FIFO's r_en from the FIFO empty flag and converts the FIFO's one-cycle registered read data into a valid/ready stream for downstream consumers. A 2-entry skid buffer sustains one word per cycle under backpressure without losing or duplicating words.

---
 rtl/fifo_stream_reader.sv | 112 +++++++++++
 tb/tb_fifo_stream_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side controller turning a registered-output FIFO into a valid/ready stream
//   clk, resetn (async, active-low), flush (sync clear of skid buffer and in-flight read)
//   fifo_empty, fifo_r_en, fifo_d_out : FIFO read port, data valid the cycle after an accepted read
//   m_valid, m_ready, m_data, m_last  : downstream stream, m_data is the skid buffer head
//   rd_count                          : delivered-word counter, wraps
//   FIFO_READER_LAST_EN               : when defined, m_last marks every BURST_LEN-th beat
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_d_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  rd_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t                  state_q, state_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic                  pop, capture;
    logic [1:0]            occ;
    logic [2:0]            pending;

    if (BURST_LEN < 1 || BURST_LEN > (2 ** CNT_WIDTH) - 1) begin : g_bad_burst
        $error("BURST_LEN out of range");
    end

    assign occ     = (state_q == EMPTY) ? 2'd0 : (state_q == ONE) ? 2'd1 : 2'd2;
    assign m_valid = state_q != EMPTY;
    assign m_data  = head_q;
    assign pop     = m_valid & m_ready;
    // returning read data is dropped while flushing
    assign capture = inflight_q & !flush;
    // words held plus words on their way, minus the one leaving this edge; pop implies occ >= 1
    assign pending   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign fifo_r_en = resetn & !fifo_empty & !flush & (pending < 3'd2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            rd_count   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_r_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (pop)
                rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush)
            state_d = EMPTY;
        else
            case (state_q)
                EMPTY: if (capture) begin
                    state_d = ONE;
                    head_d  = fifo_d_out;
                end
                ONE: if (capture && pop)
                    head_d = fifo_d_out;
                else if (capture) begin
                    state_d = TWO;
                    tail_d  = fifo_d_out;
                end else if (pop)
                    state_d = EMPTY;
                TWO: if (pop) begin
                    head_d  = tail_q;
                    tail_d  = fifo_d_out;
                    state_d = capture ? TWO : ONE;
                end
                default: state_d = EMPTY;
            endcase
    end

    // a read is only issued when a slot is guaranteed, so TWO never sees a capture
    assert property (@(posedge clk) disable iff (!resetn) !(capture && state_q == TWO));

`ifdef FIFO_READER_LAST_EN
    logic [CNT_WIDTH-1:0] burst_cnt;

    assign m_last = m_valid & (burst_cnt == CNT_WIDTH'(BURST_LEN - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            burst_cnt <= '0;
        else if (flush)
            burst_cnt <= '0;
        else if (pop)
            burst_cnt <= m_last ? '0 : burst_cnt + CNT_WIDTH'(1);
    end
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed self-checking bench for fifo_stream_reader with a registered-output FIFO model
module tb_fifo_stream_reader;
    localparam int DW = 16;
    localparam int CW = 16;
`ifdef FIFO_READER_LAST_EN
    localparam int BL = 4;
`else
    localparam int BL = 8;
`endif

    logic          clk = 1'b0, resetn = 1'b0, flush = 1'b0, m_ready = 1'b0;
    logic          fifo_empty, fifo_r_en, m_valid, m_last;
    logic [DW-1:0] fifo_d_out = '0, m_data;
    logic [CW-1:0] rd_count;
    logic [DW-1:0] mem [256];
    logic [7:0]    rd_ptr = 8'd0, wr_ptr = 8'd0;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk)
        if (fifo_r_en) begin
            fifo_d_out <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 8'd1;
        end

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_d_out(fifo_d_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .rd_count(rd_count)
    );

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m_valid, fifo_r_en, m_last} !== 3'b000 || rd_count !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b r_en=%b last=%b rd_count=%0d data=%h, want all 0",
                     m_valid, fifo_r_en, m_last, rd_count, m_data);
        end
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            checks++;
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || rd_count !== '0) begin
                errors++;
                $display("FAIL idle cyc %0d: r_en=%b valid=%b rd_count=%0d, want 0 0 0",
                         i, fifo_r_en, m_valid, rd_count);
            end
        end
    endtask

    task automatic test_stream;
        int first_ren, first_val, last_val, n;
        first_ren = -1; first_val = -1; last_val = -1; n = 0;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) push(DW'(i));
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (fifo_r_en && first_ren < 0) first_ren = c;
            if (m_valid) begin
                if (first_val < 0) first_val = c;
                last_val = c;
                checks++;
                if (m_data !== DW'(n + 1)) begin
                    errors++;
                    $display("FAIL stream beat %0d: data=%h want %h", n, m_data, DW'(n + 1));
                end
`ifndef FIFO_READER_LAST_EN
                checks++;
                if (m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL stream last beat %0d: m_last=%b want 0", n, m_last);
                end
`endif
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (first_val - first_ren != 2) begin
            errors++;
            $display("FAIL stream latency: %0d cycles want 2", first_val - first_ren);
        end
        checks++;
        if (n != 16 || last_val - first_val != 15) begin
            errors++;
            $display("FAIL stream count: %0d beats over %0d cycles want 16 over 16", n, last_val - first_val + 1);
        end
        checks++;
        if (rd_count !== CW'(16)) begin
            errors++;
            $display("FAIL stream rd_count: %0d want 16", rd_count);
        end
    endtask

    task automatic test_backpressure;
        int ren_cnt, n;
        ren_cnt = 0; n = 0;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) push(DW'(i));
        for (int c = 0; c < 45; c++) begin
            m_ready = (c >= 5);
            #1;
            if (c < 5) begin
                if (fifo_r_en) ren_cnt++;
                if (m_valid) begin
                    checks++;
                    if (m_data !== 16'h0001) begin
                        errors++;
                        $display("FAIL stall hold cyc %0d: data=%h want 0001", c, m_data);
                    end
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== DW'(n + 1)) begin
                    errors++;
                    $display("FAIL bp beat %0d: data=%h want %h", n, m_data, DW'(n + 1));
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (ren_cnt != 2) begin
            errors++;
            $display("FAIL bp r_en pulses: %0d want 2", ren_cnt);
        end
        checks++;
        if (n != 16 || rd_count !== CW'(32)) begin
            errors++;
            $display("FAIL bp totals: beats=%0d rd_count=%0d want 16 32", n, rd_count);
        end
    endtask

    task automatic test_random;
        int n, viol;
        logic hold;
        logic [DW-1:0] held, exp;
        n = 0; viol = 0; hold = 1'b0; held = '0;
        @(negedge clk);
        for (int i = 0; i < 200; i++) push(DW'(i * 37) ^ 16'h5A00);
        for (int c = 0; c < 2000 && n < 200; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (fifo_r_en && fifo_empty) viol++;
            if (hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++;
                    $display("FAIL rnd hold cyc %0d: valid=%b data=%h want 1 %h", c, m_valid, m_data, held);
                end
            end
            if (m_valid && m_ready) begin
                exp = DW'(n * 37) ^ 16'h5A00;
                checks++;
                if (m_data !== exp) begin
                    errors++;
                    $display("FAIL rnd beat %0d: data=%h want %h", n, m_data, exp);
                end
                n++;
            end
            hold = m_valid && !m_ready;
            held = m_data;
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL rnd r_en while empty: %0d times want 0", viol);
        end
        checks++;
        if (n != 200 || rd_count !== CW'(232)) begin
            errors++;
            $display("FAIL rnd totals: beats=%0d rd_count=%0d want 200 232", n, rd_count);
        end
    endtask

    task automatic test_flush;
        bit found;
        found = 1'b0;
        @(negedge clk);
        push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'hA001 || fifo_r_en !== 1'b0) begin
            errors++;
            $display("FAIL flush full: valid=%b data=%h r_en=%b want 1 a001 0", m_valid, m_data, fifo_r_en);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (fifo_r_en !== 1'b1) begin
            errors++;
            $display("FAIL flush refill r_en: %b want 1", fifo_r_en);
        end
        @(negedge clk);
        m_ready = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'hA002 || fifo_r_en !== 1'b0) begin
            errors++;
            $display("FAIL flush cycle: valid=%b data=%h r_en=%b want 1 a002 0", m_valid, m_data, fifo_r_en);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush clear: valid=%b want 0", m_valid);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (m_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || m_data !== 16'hA004) begin
            errors++;
            $display("FAIL flush next word: found=%b data=%h want 1 a004", found, m_data);
        end
        @(negedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (rd_count !== CW'(234) || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush totals: rd_count=%0d valid=%b want 234 0", rd_count, m_valid);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        found = 1'b0;
        @(negedge clk);
        push(16'hB001); push(16'hB002); push(16'hB003);
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'hB001) begin
            errors++;
            $display("FAIL rstmid pre: valid=%b data=%h want 1 b001", m_valid, m_data);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || rd_count !== '0 || fifo_r_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid async: valid=%b data=%h rd_count=%0d r_en=%b want 0 0 0 0",
                     m_valid, m_data, rd_count, fifo_r_en);
        end
        @(negedge clk);
        resetn = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (m_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || m_data !== 16'hB003) begin
            errors++;
            $display("FAIL rstmid next word: found=%b data=%h want 1 b003", found, m_data);
        end
        @(negedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (rd_count !== CW'(1)) begin
            errors++;
            $display("FAIL rstmid rd_count: %0d want 1", rd_count);
        end
    endtask

`ifdef FIFO_READER_LAST_EN
    task automatic test_last;
        int n, k;
        bit flushed;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) push(16'hD000 + DW'(i));
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            #1;
            if (m_valid) begin
                checks++;
                if (m_last !== (n % 4 == 3)) begin
                    errors++;
                    $display("FAIL last beat %0d: m_last=%b want %b", n + 1, m_last, n % 4 == 3);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL last count: %0d beats want 10", n);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 14; i++) push(16'hC000 + DW'(i));
        n = 0; k = 0; flushed = 1'b0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            flush = 1'b0; m_ready = 1'b1;
            if (n == 6 && !flushed) begin
                flush = 1'b1; m_ready = 1'b0; flushed = 1'b1;
            end
            #1;
            if (m_valid && m_ready) begin
                if (!flushed) begin
                    checks++;
                    if (m_last !== (n == 3)) begin
                        errors++;
                        $display("FAIL last pre-flush beat %0d: m_last=%b want %b", n + 1, m_last, n == 3);
                    end
                    n++;
                end else begin
                    checks++;
                    if (m_last !== (k == 3) || (k == 0 && m_data !== 16'hC008)) begin
                        errors++;
                        $display("FAIL last post-flush beat %0d: m_last=%b data=%h want %b (first c008)",
                                 k + 1, m_last, m_data, k == 3);
                    end
                    k++;
                end
            end
            @(negedge clk);
        end
        flush = 1'b0; m_ready = 1'b0;
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL last post-flush count: %0d want 6", k);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_random;
        test_flush;
        test_reset_mid;
`ifdef FIFO_READER_LAST_EN
        test_last;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
